// File: rtl/io_panel_pkg.sv
// Shared types and helpers for the front-panel I/O block: converter states,
// seven-segment encoding and BCD sizing.
package io_panel_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STORE = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low segments, bit0 = a .. bit6 = g.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Decimal digits needed to hold any val_w-bit unsigned value.
    function automatic int bcd_digits(input int val_w);
        return (val_w * 3) / 10 + 1;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-bit switch debouncer: 2-FF synchroniser followed by a stability
// counter that only lets the output flip after DB_CYCLES mismatched cycles.
module sw_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, which the synchroniser chain depends on.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            cnt  <= '0;
            db   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                db  <= ~db;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/io_panel_bcd.sv
// Front-panel I/O: debounced switch ports in, and one shared double-dabble
// (or raw hex) converter time-multiplexed over N_CH seven-segment channels.
module io_panel_bcd
    import io_panel_pkg::*;
#(
    parameter int N_IN      = 2,
    parameter int IN_W      = 5,
    parameter int N_CH      = 3,
    parameter int DIGITS    = 2,
    parameter int VAL_W     = 32,
    parameter int DB_CYCLES = 16,
    parameter int HEX_MODE  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_IN*IN_W-1:0]       sw,
    input  logic [N_CH*VAL_W-1:0]      out_val,
    output logic [N_IN*VAL_W-1:0]      in_val,
    output logic [N_CH*DIGITS*7-1:0]   hex,
    output logic [N_CH-1:0]            ovf,
    output logic                       busy
);

    localparam int N_SW   = N_IN * IN_W;
    localparam int BCD_N  = bcd_digits(VAL_W);
    localparam int BCD_W  = 4 * BCD_N;
    localparam int BCD_PW = 4 * DIGITS + BCD_W;
    localparam int BIN_PW = 4 * DIGITS + VAL_W;
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W  = $clog2(VAL_W);
    localparam int SEG_W  = DIGITS * 7;

    logic [N_SW-1:0] db_bits;

    for (genvar i = 0; i < N_SW; i++) begin : g_db
        sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (sw[i]),
            .db    (db_bits[i])
        );
    end

    for (genvar p = 0; p < N_IN; p++) begin : g_in
        assign in_val[p*VAL_W +: VAL_W] = VAL_W'(db_bits[p*IN_W +: IN_W]);
    end

    conv_state_t          state, state_nx;
    logic [CH_W-1:0]      ch;
    logic [CNT_W-1:0]     shift_cnt;
    logic [VAL_W-1:0]     bin, bin_sh;
    logic [BCD_W-1:0]     bcd, bcd_adj, bcd_sh;
    logic [BCD_PW-1:0]    bcd_pad;
    logic [BIN_PW-1:0]    bin_pad;
    logic [3:0]           nib;
    logic [SEG_W-1:0]     seg_word;
    logic                 ovf_now;
    logic [N_CH*SEG_W-1:0] hex_q;
    logic [N_CH-1:0]      ovf_q;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_LOAD;
        else       state <= state_nx;
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            ST_LOAD:  state_nx = (HEX_MODE != 0) ? ST_STORE : ST_SHIFT;
            ST_SHIFT: if (shift_cnt == CNT_W'(VAL_W - 1)) state_nx = ST_STORE;
            ST_STORE: state_nx = ST_LOAD;
            default:  state_nx = ST_LOAD;
        endcase
    end

    // One double-dabble step: add-3 correction then shift {bcd,bin} left.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        {bcd_sh, bin_sh} = {bcd_adj, bin} << 1;
    end

    // Zero padding lets DIGITS exceed the source width without range errors.
    always_comb begin
        bcd_pad  = BCD_PW'(bcd);
        bin_pad  = BIN_PW'(bin);
        nib      = '0;
        seg_word = '0;
        if (HEX_MODE != 0) ovf_now = (bin >> (4 * DIGITS)) != '0;
        else               ovf_now = (bcd >> (4 * DIGITS)) != '0;
        for (int d = 0; d < DIGITS; d++) begin
            nib = (HEX_MODE != 0) ? bin_pad[4*d +: 4] : bcd_pad[4*d +: 4];
            seg_word[7*d +: 7] = ovf_now ? SEG_DASH : seg7(nib);
        end
    end

    // NOTE: the display registers are reset explicitly so the panel comes up
    // blank instead of showing garbage until each channel is first stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch        <= '0;
            shift_cnt <= '0;
            bin       <= '0;
            bcd       <= '0;
            hex_q     <= {(N_CH * DIGITS){SEG_BLANK}};
            ovf_q     <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    bin       <= out_val[ch*VAL_W +: VAL_W];
                    bcd       <= '0;
                    shift_cnt <= '0;
                end
                ST_SHIFT: begin
                    bin       <= bin_sh;
                    bcd       <= bcd_sh;
                    shift_cnt <= shift_cnt + CNT_W'(1);
                end
                ST_STORE: begin
                    hex_q[ch*SEG_W +: SEG_W] <= seg_word;
                    ovf_q[ch]                <= ovf_now;
                    ch <= (ch == CH_W'(N_CH - 1)) ? '0 : ch + CH_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign hex  = hex_q;
    assign ovf  = ovf_q;
    assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_io_panel_bcd.sv
// Bench for io_panel_bcd: a decimal and a hex instance share clock, reset and
// switches; outputs are compared against an arithmetic reference model.
module tb_io_panel_bcd;

    localparam int N_IN = 2, IN_W = 5, N_CH = 3, DIGITS = 2, VAL_W = 32, DB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  sw = '0;
    logic [31:0] ov_d [3];
    logic [31:0] ov_h [3];
    logic [95:0] out_val_d, out_val_h;
    logic [63:0] in_val_d, in_val_h;
    logic [41:0] hex_d, hex_h;
    logic [2:0]  ovf_d, ovf_h;
    logic        busy_d, busy_h;

    int n_cmp = 0;
    int n_bad = 0;
    bit busy_h_seen = 1'b0;

    always #5 clk = ~clk;

    assign out_val_d = {ov_d[2], ov_d[1], ov_d[0]};
    assign out_val_h = {ov_h[2], ov_h[1], ov_h[0]};

    io_panel_bcd #(.N_IN(N_IN), .IN_W(IN_W), .N_CH(N_CH), .DIGITS(DIGITS),
                   .VAL_W(VAL_W), .DB_CYCLES(DB), .HEX_MODE(0)) u_dec (
        .clk(clk), .reset(reset), .sw(sw), .out_val(out_val_d),
        .in_val(in_val_d), .hex(hex_d), .ovf(ovf_d), .busy(busy_d)
    );

    io_panel_bcd #(.N_IN(N_IN), .IN_W(IN_W), .N_CH(N_CH), .DIGITS(DIGITS),
                   .VAL_W(VAL_W), .DB_CYCLES(DB), .HEX_MODE(1)) u_hex (
        .clk(clk), .reset(reset), .sw(sw), .out_val(out_val_h),
        .in_val(in_val_h), .hex(hex_h), .ovf(ovf_h), .busy(busy_h)
    );

    always @(negedge clk) if (!reset && busy_h) busy_h_seen = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [6:0] seg_of(input int n);
        case (n)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  15: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] dec_segs(input logic [31:0] v);
        if (v >= 32'd100) return {7'b0111111, 7'b0111111};
        return {seg_of(int'((v / 10) % 10)), seg_of(int'(v % 10))};
    endfunction

    function automatic logic [13:0] hex_segs(input logic [31:0] v);
        if ((v >> 8) != 0) return {7'b0111111, 7'b0111111};
        return {seg_of(int'((v >> 4) & 32'hF)), seg_of(int'(v & 32'hF))};
    endfunction

    function automatic logic [63:0] in_model(input logic [9:0] s);
        logic [63:0] r = '0;
        for (int p = 0; p < N_IN; p++)
            for (int b = 0; b < IN_W; b++) r[p*VAL_W + b] = s[p*IN_W + b];
        return r;
    endfunction

    function automatic logic [31:0] rnd_dec();
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 99);
            1: return $urandom_range(99, 100);
            2: return $urandom_range(101, 99999);
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rnd_hex();
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 255);
            1: return $urandom_range(255, 256);
            2: return $urandom_range(257, 65535);
            default: return $urandom;
        endcase
    endfunction

    task automatic check_dec(input string tag);
        for (int c = 0; c < N_CH; c++) begin
            check($sformatf("%s_dec_hex%0d", tag, c), 64'(hex_d[c*14 +: 14]), 64'(dec_segs(ov_d[c])));
            check($sformatf("%s_dec_ovf%0d", tag, c), 64'(ovf_d[c]), 64'(ov_d[c] >= 32'd100));
        end
    endtask

    task automatic check_hex(input string tag);
        for (int c = 0; c < N_CH; c++) begin
            check($sformatf("%s_hx_hex%0d", tag, c), 64'(hex_h[c*14 +: 14]), 64'(hex_segs(ov_h[c])));
            check($sformatf("%s_hx_ovf%0d", tag, c), 64'(ovf_h[c]), 64'((ov_h[c] >> 8) != 0));
        end
    endtask

    initial begin
        bit glitch;
        logic [41:0] blank = '1;

        // Reset with arbitrary inputs
        sw = 10'($urandom);
        for (int c = 0; c < N_CH; c++) begin
            ov_d[c] = $urandom;
            ov_h[c] = $urandom;
        end
        reset = 1'b1;
        tick(3);
        check("rst_hex_d", 64'(hex_d), 64'(blank));
        check("rst_hex_h", 64'(hex_h), 64'(blank));
        check("rst_ovf", 64'({ovf_d, ovf_h}), 64'(0));
        check("rst_in_val", in_val_d, 64'(0));
        check("rst_busy", 64'({busy_d, busy_h}), 64'(0));

        // Decimal 42/7/99 and hex 0x3A after reset release
        sw = '0;
        ov_d[0] = 32'd42; ov_d[1] = 32'd7; ov_d[2] = 32'd99;
        ov_h[0] = 32'h3A; ov_h[1] = rnd_hex(); ov_h[2] = rnd_hex();
        reset = 1'b0;
        tick(1);
        check("dec_blank_pre_store", 64'(hex_d), 64'(blank));
        tick(1);
        check("hx_load_store", 64'(hex_h[13:0]), 64'({7'b0110000, 7'b0001000}));
        check("dec_still_blank", 64'(hex_d), 64'(blank));
        tick(100);
        check("dec_42", 64'(hex_d[13:0]), 64'({7'b0011001, 7'b0100100}));
        check_dec("first_refresh");

        // Snapshot: change ch0 at the 10th SHIFT cycle of its conversion
        reset = 1'b1;
        tick(2);
        ov_d[0] = 32'd42;
        reset = 1'b0;
        tick(11);
        check("snap_busy", 64'(busy_d), 64'(1));
        ov_d[0] = 32'd13;
        tick(23);
        check("snap_old", 64'(hex_d[13:0]), 64'(dec_segs(32'd42)));
        check("snap_ch1_blank", 64'(hex_d[27:14]), 64'(14'h3FFF));
        tick(102);
        check("snap_new", 64'(hex_d[13:0]), 64'(dec_segs(32'd13)));

        // Reset during SHIFT of ch1: next STORE must be ch0
        tick(10);
        check("mid_busy", 64'(busy_d), 64'(1));
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(34);
        check("mid_ch0", 64'(hex_d[13:0]), 64'(dec_segs(32'd13)));
        check("mid_ch12_blank", 64'(hex_d[41:14]), 64'(28'hFFFFFFF));
        check("mid_ovf", 64'(ovf_d), 64'(0));

        // Debounce: glitch of DB-1 cycles is ignored
        sw = 10'd1;
        tick(DB - 1);
        sw = '0;
        glitch = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (in_val_d != '0) glitch = 1'b1;
        end
        check("db_glitch", 64'(glitch), 64'(0));

        // Debounce latency 2+DB cycles
        sw = 10'd1;
        tick(DB + 1);
        check("db_lat_early", 64'(in_val_d[0]), 64'(0));
        tick(1);
        check("db_lat", 64'(in_val_d[0]), 64'(1));

        sw = 10'h080;
        tick(DB + 4);
        check("db_sw7", 64'(in_val_d[VAL_W + 2]), 64'(1));
        check("db_sw7_full", in_val_d, in_model(sw));

        for (int r = 0; r < 4; r++) begin
            sw = 10'($urandom);
            tick(DB + 4);
            check($sformatf("db_rand%0d_d", r), in_val_d, in_model(sw));
            check($sformatf("db_rand%0d_h", r), in_val_h, in_model(sw));
        end

        // Overflow sequence on ch1
        ov_d[1] = 32'd100;
        tick(206);
        check_dec("ovf_100");
        ov_d[1] = 32'hFFFF_FFFF;
        tick(206);
        check_dec("ovf_max");
        ov_d[1] = 32'd5;
        tick(136);
        check_dec("ovf_clear");

        // Hex overflow
        ov_h[0] = 32'h1FF;
        tick(8);
        check_hex("hx_1ff");

        // Randomised rounds on both instances
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < N_CH; c++) begin
                ov_d[c] = rnd_dec();
                ov_h[c] = rnd_hex();
            end
            tick(206);
            check_dec($sformatf("rand%0d", r));
            check_hex($sformatf("rand%0d", r));
        end

        check("hx_busy_never", 64'(busy_h_seen), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
